// File: rtl/program_fetch8_if.sv
// Fetch-to-ROM and fetch-to-decode signal bundle for program_fetch8.
interface program_fetch8_if #(
    parameter int unsigned INSTR_BYTES = 4
);
    localparam int unsigned INSTR_W = 8 * INSTR_BYTES;

    // ROM side
    logic [15:0]        rom_address;
    logic [7:0]         rom_data;
    // Decode side
    logic [INSTR_W-1:0] instr;
    logic [15:0]        instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    // Redirect
    logic               jump;
    logic [15:0]        jump_target;

    // Fetch stage drives addresses and instruction words
    modport master (
        output rom_address,
        output instr,
        output instr_pc,
        output instr_valid,
        input  rom_data,
        input  instr_ready,
        input  jump,
        input  jump_target
    );

    // ROM / decode / branch unit view
    modport slave (
        input  rom_address,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output rom_data,
        output instr_ready,
        output jump,
        output jump_target
    );
endinterface

// File: rtl/program_fetch8.sv
// Instruction fetch: reads INSTR_BYTES consecutive ROM bytes, packs them
// little-endian into one word and offers it to decode via valid/ready.
module program_fetch8 #(
    parameter int unsigned INSTR_BYTES = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    program_fetch8_if.master bus
);
    localparam int unsigned INSTR_W = 8 * INSTR_BYTES;
    localparam int unsigned CNT_W   = $clog2(INSTR_BYTES + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0] asm_q, asm_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        instr_pc_q, instr_pc_d;
    logic               fill_done;

    assign fill_done = (state_q == FILL) && (cnt_q == CNT_W'(INSTR_BYTES));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: jump wins, else FILL->HOLD on last byte, HOLD->FILL on handshake
    always_comb begin
        state_d = state_q;
        if (bus.jump) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (fill_done) state_d = HOLD;
                HOLD:    if (bus.instr_ready) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // Outputs: byte address and word valid decoded from registered state
    always_comb begin
        bus.rom_address = fetch_pc_q;
        bus.instr_valid = 1'b0;
        case (state_q)
            FILL:    bus.rom_address = fetch_pc_q + 16'(cnt_q);
            HOLD:    bus.instr_valid = 1'b1;
            default: bus.rom_address = fetch_pc_q;
        endcase
    end

    // Datapath next values: byte capture, word publish, PC advance / redirect
    always_comb begin
        cnt_d      = cnt_q;
        fetch_pc_d = fetch_pc_q;
        asm_d      = asm_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (bus.jump) begin
            // Partial bytes are abandoned; cnt=0 keeps the stale ROM byte out
            fetch_pc_d = bus.jump_target;
            cnt_d      = '0;
        end else if (state_q == FILL) begin
            // rom_data answers the address issued at cnt-1
            for (int unsigned k = 0; k < INSTR_BYTES; k++) begin
                if (cnt_q == CNT_W'(k + 1)) begin
                    asm_d[8*k +: 8] = bus.rom_data;
                end
            end
            if (fill_done) begin
                instr_d    = asm_d;
                instr_pc_d = fetch_pc_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.instr_ready) begin
            fetch_pc_d = fetch_pc_q + 16'(INSTR_BYTES);
            cnt_d      = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            fetch_pc_q <= RESET_PC;
            asm_q      <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.instr    = instr_q;
    assign bus.instr_pc = instr_pc_q;

endmodule

// File: tb/tb_program_fetch8.sv
// Directed bench for program_fetch8 with a 1-cycle-latency ROM model.
module tb_program_fetch8;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   xfers;

    program_fetch8_if #(.INSTR_BYTES(4)) bus ();

    program_fetch8 #(
        .INSTR_BYTES(4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: 0..7 hold 11,22,...,88; elsewhere lo^hi^A5
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] n;
        if (a < 16'd8) begin
            n = 8'(a[2:0]) + 8'd1;
            return n * 8'h11;
        end
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // ROM with one cycle of read latency
    always @(posedge clk) bus.rom_data <= rom_byte(bus.rom_address);

    // Completed decode transfers
    always @(posedge clk) if (bus.instr_valid && bus.instr_ready) xfers <= xfers + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset for two edges, check cleared outputs, release at a negedge (cycle 0)
    task automatic do_reset();
        rst = 1'b0;
        bus.jump = 1'b0;
        bus.jump_target = 16'h0000;
        step(2);
        check_eq("rst_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("rst_instr", 64'(bus.instr), 64'd0);
        check_eq("rst_pc", 64'(bus.instr_pc), 64'd0);
        check_eq("rst_addr", 64'(bus.rom_address), 64'h0000);
        rst = 1'b1;
    endtask

    task automatic check_word(input string tag, input logic [15:0] pc, input logic [31:0] w);
        check_eq({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
        check_eq({tag, "_pc"}, 64'(bus.instr_pc), 64'(pc));
        check_eq({tag, "_instr"}, 64'(bus.instr), 64'(w));
    endtask

    initial begin
        int x0;
        n_checks = 0;
        n_fail   = 0;
        xfers    = 0;
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jump = 1'b0;
        bus.jump_target = 16'h0000;

        // Basic fetch, ready tied high
        bus.instr_ready = 1'b1;
        do_reset();
        check_eq("c0_addr", 64'(bus.rom_address), 64'h0000);
        check_eq("c0_valid", 64'(bus.instr_valid), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            step(1);
            check_eq("fill_addr", 64'(bus.rom_address), 64'(c));
        end
        step(1);
        check_eq("c4_valid", 64'(bus.instr_valid), 64'd0);
        step(1);
        check_word("c5", 16'h0000, 32'h44332211);
        check_eq("c5_addr", 64'(bus.rom_address), 64'h0000);
        step(1);
        check_eq("c6_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("c6_addr", 64'(bus.rom_address), 64'h0004);
        step(5);
        check_word("c11", 16'h0004, 32'h88776655);

        // Backpressure for 10 cycles, then one cycle of ready
        bus.instr_ready = 1'b0;
        do_reset();
        step(5);
        check_word("bp0", 16'h0000, 32'h44332211);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_word("bp", 16'h0000, 32'h44332211);
            check_eq("bp_addr", 64'(bus.rom_address), 64'h0000);
        end
        bus.instr_ready = 1'b1;
        step(1);
        bus.instr_ready = 1'b0;
        check_eq("bp_rel_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("bp_rel_addr", 64'(bus.rom_address), 64'h0004);

        // Jump in cycle 2 of fetching PC 0
        bus.instr_ready = 1'b1;
        do_reset();
        step(2);
        bus.jump = 1'b1;
        bus.jump_target = 16'h0040;
        step(1);
        bus.jump = 1'b0;
        check_eq("jmp_addr", 64'(bus.rom_address), 64'h0040);
        check_eq("jmp_valid", 64'(bus.instr_valid), 64'd0);
        step(4);
        check_eq("jmp_c4_valid", 64'(bus.instr_valid), 64'd0);
        step(1);
        check_word("jmp", 16'h0040, 32'hE6E7E4E5);

        // Jump coinciding with a handshake
        x0 = xfers;
        bus.jump = 1'b1;
        bus.jump_target = 16'h0080;
        step(1);
        bus.jump = 1'b0;
        check_eq("jhs_addr", 64'(bus.rom_address), 64'h0080);
        check_eq("jhs_valid", 64'(bus.instr_valid), 64'd0);
        step(5);
        check_word("jhs", 16'h0080, 32'h26272425);
        check_eq("jhs_xfers", 64'(xfers - x0), 64'd1);

        // Address wrap at top of memory
        bus.jump = 1'b1;
        bus.jump_target = 16'hFFFE;
        step(1);
        bus.jump = 1'b0;
        check_eq("wrap_a0", 64'(bus.rom_address), 64'hFFFE);
        step(1);
        check_eq("wrap_a1", 64'(bus.rom_address), 64'hFFFF);
        step(1);
        check_eq("wrap_a2", 64'(bus.rom_address), 64'h0000);
        step(1);
        check_eq("wrap_a3", 64'(bus.rom_address), 64'h0001);
        step(2);
        check_word("wrap", 16'hFFFE, 32'h2211A5A4);
        step(6);
        check_word("wrap_next", 16'h0002, 32'h66554433);

        // Async reset while cnt=2 of the fetch at PC 6
        step(3);
        check_eq("mid_addr", 64'(bus.rom_address), 64'h0008);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_addr", 64'(bus.rom_address), 64'h0000);
        check_eq("arst_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("arst_instr", 64'(bus.instr), 64'd0);
        check_eq("arst_pc", 64'(bus.instr_pc), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        check_eq("arst_c0_addr", 64'(bus.rom_address), 64'h0000);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check_eq("arst_lat_valid", 64'(bus.instr_valid), 64'd0);
        end
        step(1);
        check_word("arst_re", 16'h0000, 32'h44332211);

        // Async reset while holding a word
        #2 rst = 1'b0;
        #1;
        check_eq("hrst_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("hrst_instr", 64'(bus.instr), 64'd0);
        check_eq("hrst_pc", 64'(bus.instr_pc), 64'd0);
        check_eq("hrst_addr", 64'(bus.rom_address), 64'h0000);
        @(negedge clk);
        rst = 1'b1;
        step(4);
        check_eq("hrst_lat_valid", 64'(bus.instr_valid), 64'd0);
        step(1);
        check_word("hrst_re", 16'h0000, 32'h44332211);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
